// File: rtl/axi_lite_hwinfo_regs.sv
// AXI-Lite register block: eight read-only hardware-info words and eight RW config words.
// Optional read-only access counter at offset 0x40 when AXIL_HWINFO_ACCESS_CNT_EN is defined.
//
// state  | meaning
// W_IDLE | accepting AW and W independently, commit once both are held
// W_RESP | write response presented, waiting for b_ready_i
// R_IDLE | accepting AR
// R_RESP | read data presented, waiting for r_ready_i
module axi_lite_hwinfo_regs #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiStrbWidth = AxiDataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AxiAddrWidth-1:0] aw_addr_i,
  input  logic [2:0]              aw_prot_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [AxiStrbWidth-1:0] w_strb_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [AxiAddrWidth-1:0] ar_addr_i,
  input  logic [2:0]              ar_prot_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  input  logic [7:0][31:0]        info_i,
  output logic [7:0][31:0]        cfg_o
);

  localparam int unsigned NumLanes   = AxiDataWidth / 32;
  localparam logic [1:0]  LaneMask   = 2'(NumLanes - 1);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e                r_w_state;
  w_state_e                w_w_state_nxt;
  r_state_e                r_r_state;
  r_state_e                w_r_state_nxt;

  logic                    r_live;
  logic                    r_aw_got;
  logic                    r_w_got;
  logic [5:0]              r_aw_idx;
  logic [1:0]              r_aw_lane;
  logic [AxiDataWidth-1:0] r_w_data;
  logic [AxiStrbWidth-1:0] r_w_strb;
  logic [1:0]              r_b_resp;
  logic [7:0][31:0]        r_cfg;
  logic [AxiDataWidth-1:0] r_rd_data;
  logic [1:0]              r_rd_resp;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_commit;
  logic [5:0]              w_wr_idx;
  logic [1:0]              w_wr_lane;
  logic [AxiDataWidth-1:0] w_wr_data;
  logic [AxiStrbWidth-1:0] w_wr_strb;
  logic [31:0]             w_lane_data;
  logic [3:0]              w_lane_strb;
  logic                    w_wr_ok;
  logic [5:0]              w_rd_idx;
  logic [31:0]             w_rd_word;
  logic [1:0]              w_rd_resp;
  logic                    w_unused_ok;

  // Readies stay low through reset and rise on the first clock after release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_live <= 1'b0;
    else         r_live <= 1'b1;
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_w_state <= W_IDLE;
    else         r_w_state <= w_w_state_nxt;
  end

  always_comb begin
    w_w_state_nxt = r_w_state;
    case (r_w_state)
      W_IDLE:  if (w_commit)  w_w_state_nxt = W_RESP;
      W_RESP:  if (b_ready_i) w_w_state_nxt = W_IDLE;
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        aw_ready_o = r_live & ~r_aw_got;
        w_ready_o  = r_live & ~r_w_got;
      end
      W_RESP:  b_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign b_resp_o = r_b_resp;

  assign w_aw_hs  = aw_valid_i & aw_ready_o;
  assign w_w_hs   = w_valid_i & w_ready_o;
  assign w_commit = (r_w_state == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);

  // A same-cycle handshake bypasses the capture registers.
  assign w_wr_idx    = r_aw_got ? r_aw_idx : aw_addr_i[7:2];
  assign w_wr_lane   = (r_aw_got ? r_aw_lane : aw_addr_i[3:2]) & LaneMask;
  assign w_wr_data   = r_w_got ? r_w_data : w_data_i;
  assign w_wr_strb   = r_w_got ? r_w_strb : w_strb_i;
  assign w_lane_data = w_wr_data[{w_wr_lane, 5'b00000} +: 32];
  assign w_lane_strb = w_wr_strb[{w_wr_lane, 2'b00} +: 4];
  assign w_wr_ok     = (w_wr_idx[5:3] == 3'b001);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_lane <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_resp  <= RespOkay;
    end else if (w_commit) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_b_resp <= w_wr_ok ? RespOkay : RespSlverr;
    end else begin
      if (w_aw_hs) begin
        r_aw_got  <= 1'b1;
        r_aw_idx  <= aw_addr_i[7:2];
        r_aw_lane <= aw_addr_i[3:2];
      end
      if (w_w_hs) begin
        r_w_got  <= 1'b1;
        r_w_data <= w_data_i;
        r_w_strb <= w_strb_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_lane_strb[b]) r_cfg[w_wr_idx[2:0]][b*8 +: 8] <= w_lane_data[b*8 +: 8];
      end
    end
  end

  assign cfg_o = r_cfg;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_r_state <= R_IDLE;
    else         r_r_state <= w_r_state_nxt;
  end

  always_comb begin
    w_r_state_nxt = r_r_state;
    case (r_r_state)
      R_IDLE:  if (w_ar_hs)   w_r_state_nxt = R_RESP;
      R_RESP:  if (r_ready_i) w_r_state_nxt = R_IDLE;
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    case (r_r_state)
      R_IDLE:  ar_ready_o = r_live;
      R_RESP:  r_valid_o  = 1'b1;
      default: ;
    endcase
  end

  assign w_ar_hs  = ar_valid_i & ar_ready_o;
  assign w_rd_idx = ar_addr_i[7:2];

`ifdef AXIL_HWINFO_ACCESS_CNT_EN
  logic [31:0] r_acc_cnt;
  logic        w_b_hs;
  logic        w_r_hs;

  assign w_b_hs = b_valid_o & b_ready_i;
  assign w_r_hs = r_valid_o & r_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_acc_cnt <= '0;
    else         r_acc_cnt <= r_acc_cnt + 32'(w_b_hs) + 32'(w_r_hs);
  end
`endif

  // RW words are read from the registered copy, so a same-edge write is not yet visible.
  always_comb begin
    w_rd_word = '0;
    w_rd_resp = RespSlverr;
    if (w_rd_idx[5:3] == 3'b000) begin
      w_rd_word = info_i[w_rd_idx[2:0]];
      w_rd_resp = RespOkay;
    end else if (w_rd_idx[5:3] == 3'b001) begin
      w_rd_word = r_cfg[w_rd_idx[2:0]];
      w_rd_resp = RespOkay;
    end
`ifdef AXIL_HWINFO_ACCESS_CNT_EN
    else if (w_rd_idx == 6'd16) begin
      w_rd_word = r_acc_cnt;
      w_rd_resp = RespOkay;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data <= '0;
      r_rd_resp <= RespOkay;
    end else if (w_ar_hs) begin
      r_rd_data <= {NumLanes{w_rd_word}};
      r_rd_resp <= w_rd_resp;
    end
  end

  assign r_data_o = r_rd_data;
  assign r_resp_o = r_rd_resp;

  // Protection bits and out-of-window address bits carry no meaning here.
  assign w_unused_ok = ^{aw_prot_i, ar_prot_i,
                         aw_addr_i[AxiAddrWidth-1:8], aw_addr_i[1:0],
                         ar_addr_i[AxiAddrWidth-1:8], ar_addr_i[1:0]};

endmodule

// File: doc/axi_lite_hwinfo_regs.md
AXI_LITE_HWINFO_REGS -- requirements
Module: axi_lite_hwinfo_regs

Interface
REQ-001 SHALL have parameter AxiAddrWidth, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter AxiDataWidth, default 128, AXI-Lite data width; legal values are 32, 64 and 128.
REQ-003 SHALL have parameter AxiStrbWidth, default 16, equal to AxiDataWidth/8.
REQ-004 SHALL have ports clk_i in 1 (single clock) and rst_ni in 1 (asynchronous, active-low reset).
REQ-005 SHALL have write-address ports aw_addr_i in AxiAddrWidth, aw_prot_i in 3, aw_valid_i in 1 and aw_ready_o out 1.
REQ-006 SHALL have write-data ports w_data_i in AxiDataWidth, w_strb_i in AxiStrbWidth, w_valid_i in 1 and w_ready_o out 1.
REQ-007 SHALL have write-response ports b_resp_o out 2, b_valid_o out 1 and b_ready_i in 1.
REQ-008 SHALL have read-address ports ar_addr_i in AxiAddrWidth, ar_prot_i in 3, ar_valid_i in 1 and ar_ready_o out 1.
REQ-009 SHALL have read-data ports r_data_o out AxiDataWidth, r_resp_o out 2, r_valid_o out 1 and r_ready_i in 1.
REQ-010 SHALL have port info_i in 8x32, the read-only hardware-info words.
REQ-011 SHALL have port cfg_o out 8x32, the current contents of the read/write registers.

Function
REQ-012 SHALL decode offset = addr[7:0] and register index = offset[7:2]; addr[1:0] and all bits above bit 7 are ignored, because routing is done upstream.
REQ-013 SHALL map index 0-7 to info_i[idx] (read-only) and index 8-15 to RW register idx-8; any other index is unmapped.
REQ-014 SHALL, on a read, place the 32-bit word in every 32-bit lane of r_data_o.
REQ-015 SHALL, on a write, take the lane selected by addr[$clog2(AxiStrbWidth)-1:2] (lane 0 when AxiDataWidth=32) and update only the bytes whose strobe in that lane is 1.
REQ-016 SHALL run the write FSM with states W_IDLE and W_RESP.
- In W_IDLE, aw_ready_o=1 until an AW is captured and w_ready_o=1 until a W is captured; AW and W are accepted independently, in either order or in the same cycle.
- When both are held, the write commits at that clock edge and the FSM moves to W_RESP with b_valid_o=1.
REQ-017 SHALL, in W_RESP, hold b_valid_o and b_resp_o stable with aw_ready_o=w_ready_o=0 until b_ready_i=1, then return to W_IDLE with the captured flags cleared.
REQ-018 SHALL run the read FSM with states R_IDLE (ar_ready_o=1) and R_RESP (ar_ready_o=0, r_valid_o=1).
- An AR handshake at cycle N gives r_valid_o=1 at cycle N+1.
- r_data_o and r_resp_o are held stable until r_ready_i=1.
REQ-019 SHALL respond OKAY (2'b00) to a mapped read or to a write to index 8-15.
REQ-020 SHALL respond SLVERR (2'b10) to an unmapped read (r_data_o=0), to an unmapped write, and to a write to index 0-7; such writes have no effect.
REQ-021 SHALL sample read data at the AR handshake edge; if a write to the same register commits at that same edge, the read returns the pre-write value.
REQ-022 SHALL let the read and write FSMs operate fully concurrently without interlock.
REQ-023 SHALL treat a write with all selected-lane strobes 0 as a no-op with an OKAY response (SLVERR rules still apply).
REQ-024 SHALL ignore aw_prot_i and ar_prot_i.

Reset
REQ-025 SHALL, while rst_ni=0, asynchronously force:
- both FSMs to idle;
- the captured flags to 0;
- all RW registers and cfg_o to 0;
- b_valid_o=r_valid_o=0 and b_resp_o=r_resp_o=0;
- r_data_o=0.
REQ-026 SHALL drive aw_ready_o, w_ready_o and ar_ready_o to 0 during reset and to 1 from the first clock after rst_ni rises.
REQ-027 SHALL abandon any in-flight transaction on reset, issuing no response afterwards.

Configuration
REQ-028 SHALL, when macro AXIL_HWINFO_ACCESS_CNT_EN is defined:
- map index 16 (offset 0x40) to a read-only 32-bit counter that is reset to 0;
- increment the counter by 1 on every B or R handshake, by 2 if both occur in the same cycle, wrapping modulo 2^32;
- treat a write to index 16 as a write to a read-only register (SLVERR).
REQ-029 SHALL, when AXIL_HWINFO_ACCESS_CNT_EN is undefined, include no counter and treat index 16 as unmapped.

Verification
REQ-030 SHALL cover: reset released; AR 0x04 with info_i[1]=32'hCAFE0001 -> r_valid_o=1 one cycle later, every lane 32'hCAFE0001, OKAY.
REQ-031 SHALL cover: W (data lane2=32'h12345678, strb=16'h0F00) one cycle before AW 0x28 -> cfg_o[2]=32'h12345678 and b_resp_o=OKAY the cycle after AW.
REQ-032 SHALL cover: write to 0x08 -> SLVERR and info unchanged; read from 0x80 -> SLVERR with r_data_o=0.
REQ-033 SHALL cover: b_ready_i held 0 for 5 cycles -> b_valid_o and b_resp_o stable and aw_ready_o=0 throughout.
REQ-034 SHALL cover: same-edge write 32'hA5A5A5A5 and read to 0x20 -> read returns the old value; the next read returns 32'hA5A5A5A5.
REQ-035 SHALL cover, with AXIL_HWINFO_ACCESS_CNT_EN: 3 reads plus 2 writes, then read 0x40 -> 32'd5; without the macro, reading 0x40 -> SLVERR.
